evu_evt_sched: RTL and testbench
================================

EVU_EVT_SCHED -- requirements
Module: evu_evt_sched

Interface
REQ-001 Parameter NUM_SRC, default 4: number of event sources (EVU mux lines) shared onto one output; range 2..16.
REQ-002 Parameter CNT_W, default 4: width of each per-source pending counter and of out_cnt_o.
REQ-003 Parameter INFO_W, default 18: width of the context tag (priv level 2 b + ASID).
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 en_i  in  1  scheduler enable, from EVU config register.
REQ-007 src_mask_i  in  NUM_SRC  per-source enable; 0 ignores that source's events.
REQ-008 evt_i  in  NUM_SRC  per-source event pulse; one event per set bit per cycle.
REQ-009 info_i  in  INFO_W  current context tag {priv, asid}.
REQ-010 out_valid_o  out  1  output record valid.
REQ-011 out_ready_i  in  1  consumer (SPU interface) ready.
REQ-012 out_id_o  out  $clog2(NUM_SRC)  source index of record.
REQ-013 out_cnt_o  out  CNT_W  coalesced event count of record (1..2^CNT_W-1).
REQ-014 out_info_o  out  INFO_W  context tag captured at grant.
REQ-015 drop_o  out  1  pulses 1 cycle when >=1 event lost this cycle.
REQ-016 drop_cnt_o  out  16  total lost events, saturating at 16'hFFFF.

Function
REQ-017 Accepted event: evt_i[k] & src_mask_i[k] & en_i; all others ignored, neither counted nor dropped.
REQ-018 Per-source pending counter pend[k]: +1 per accepted event, saturates at 2^CNT_W-1; accepted event while saturated is dropped.
REQ-019 Output register is one stage; load permitted when load_ok = !out_valid_o | out_ready_i.
REQ-020 Grant when load_ok & en_i & some pend[k]!=0: round-robin, search starts at index last_grant+1 modulo NUM_SRC, first nonzero wins.
REQ-021 On grant of k: out_id_o<=k, out_cnt_o<=pend[k], out_info_o<=info_i, out_valid_o<=1, last_grant<=k, pend[k]<=0.
REQ-022 Same-cycle grant of k and accepted event on k: pend[k]<=1 (event goes to next record, never lost).
REQ-023 FSM IDLE (out_valid_o=0) / VALID (out_valid_o=1): IDLE->VALID on grant; VALID->IDLE on out_ready_i with no grant; VALID->VALID on out_ready_i with grant (back-to-back, one record per cycle) or on !out_ready_i.
REQ-024 In VALID with out_ready_i=0, out_id_o/out_cnt_o/out_info_o SHALL stay stable.
REQ-025 en_i=0: no grants, no increments; pending counters retained; a record already valid stays valid until accepted.
REQ-026 Counting/clearing src_mask_i[k] does not clear pend[k]; pending counts still granted while en_i=1.
REQ-027 drop_o = registered OR of all drops in a cycle (asserted the cycle after); drop_cnt_o adds number of drops that cycle (0..NUM_SRC), saturating.
REQ-028 Starvation bound: a source with pend!=0 is granted within NUM_SRC grants.

Reset
REQ-029 rst_ni=0 at clock edge: all pend=0, out_valid_o=0, out_id_o=0, out_cnt_o=0, out_info_o=0, drop_o=0, drop_cnt_o=0, last_grant=NUM_SRC-1 (source 0 searched first), FSM IDLE.
REQ-030 Reset mid-record discards pending and held records; no record emitted in the cycle after rst_ni rises unless an event arrives that cycle (earliest valid: 2 cycles after first accepted event).

Verification
REQ-031 Reset, en_i=1, mask=4'hF, evt_i=4'b0001 one cycle, ready=1 -> next cycle out_valid_o=1, out_id_o=0, out_cnt_o=1, then IDLE.
REQ-032 ready=0, evt_i=4'b1111 for 3 cycles -> first record id0 cnt1; after ready=1, records id1,id2,id3 back-to-back each cnt3, then id0 cnt2.
REQ-033 ready=0, record held, evt_i[2]=1 for 20 cycles -> pend[2] saturates at 15, 5 drops, drop_cnt_o=5, drop_o high 5 cycles; held record fields unchanged throughout.
REQ-034 Grant of source 1 same cycle as evt_i[1] -> out_cnt_o=old count, pend[1]=1, next record id1 cnt1.
REQ-035 en_i=0 with pend[3]=2 and valid record, ready=1 -> record accepted, no new grant, pend[3] stays 2; en_i=1 -> id3 cnt2 next cycle.
REQ-036 Assert rst_ni=0 with out_valid_o=1 and drop_cnt_o=7 -> next cycle all outputs 0, out_valid_o=0.

Source files
------------

// File: rtl/evu_evt_sched.sv
// evu_evt_sched: coalesces per-source event pulses into pending counters and
// schedules them round-robin onto a single one-stage valid/ready record output.
// Latency: an event is counted at the next edge and its record is valid one edge later (2 cycles).
// Backpressure: a held record stays frozen while out_ready_i=0; events keep coalescing, overflow is dropped.
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   en_i                    scheduler enable (gates counting and granting)
//   src_mask_i, evt_i       per-source enable and per-source event pulse
//   info_i                  context tag {priv, asid} captured into each record
//   out_valid_o/out_ready_i record handshake
//   out_id_o/out_cnt_o/out_info_o  record fields: source, coalesced count, tag
//   drop_o, drop_cnt_o      lost-event pulse (one cycle late) and saturating total
module evu_evt_sched #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 4,
  parameter int INFO_W  = 18
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [NUM_SRC-1:0]         src_mask_i,
  input  logic [NUM_SRC-1:0]         evt_i,
  input  logic [INFO_W-1:0]          info_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(NUM_SRC)-1:0] out_id_o,
  output logic [CNT_W-1:0]           out_cnt_o,
  output logic [INFO_W-1:0]          out_info_o,
  output logic                       drop_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int ID_W = $clog2(NUM_SRC);
  localparam int DN_W = $clog2(NUM_SRC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SRC-1:0][CNT_W-1:0] pend_q, pend_d;
  logic [ID_W-1:0]               last_grant_q;
  logic [NUM_SRC-1:0]            accept;
  logic [NUM_SRC-1:0]            pend_nz;
  logic [NUM_SRC-1:0]            drop_vec;
  logic                          load_ok;
  logic                          grant;
  logic [ID_W-1:0]               grant_id;
  logic [CNT_W-1:0]              grant_cnt;
  int                            arb_dist;
  int                            arb_best;
  logic [DN_W-1:0]               drop_num;
  logic [16:0]                   drop_sum;

  logic [ID_W-1:0]   out_id_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [INFO_W-1:0] out_info_q;
  logic              drop_q;
  logic [15:0]       drop_cnt_q;

  // Masked or disabled events are ignored outright: neither counted nor dropped.
  assign accept  = evt_i & src_mask_i & {NUM_SRC{en_i}};
  assign load_ok = (state_q == IDLE) || out_ready_i;

  always_comb begin
    pend_nz = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pend_nz[k] = (pend_q[k] != '0);
    end
  end

  // Round-robin pick: each source's priority is its distance from the slot
  // just after last_grant_q, so the nearest non-empty source wins.
  always_comb begin
    arb_dist  = 0;
    arb_best  = NUM_SRC;
    grant_id  = '0;
    grant_cnt = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      arb_dist = (k + NUM_SRC - 1 - int'(last_grant_q)) % NUM_SRC;
      if (pend_nz[k] && (arb_dist < arb_best)) begin
        arb_best  = arb_dist;
        grant_id  = ID_W'(k);
        grant_cnt = pend_q[k];
      end
    end
    grant = load_ok && en_i && (arb_best < NUM_SRC);
  end

  // Counter update. A granted source is emptied first, so an event arriving
  // in the grant cycle starts the next record at 1 instead of being lost.
  always_comb begin
    pend_d   = pend_q;
    drop_vec = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant && (grant_id == ID_W'(k))) begin
        pend_d[k] = accept[k] ? CNT_W'(1) : '0;
      end else if (accept[k]) begin
        if (pend_q[k] == CNT_MAX) begin
          drop_vec[k] = 1'b1;
        end else begin
          pend_d[k] = pend_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    drop_num = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      drop_num = drop_num + DN_W'(drop_vec[k]);
    end
    drop_sum = {1'b0, drop_cnt_q} + 17'(drop_num);
  end

  // Output FSM: VALID holds a record; a grant while the record drains keeps
  // VALID so records can stream back-to-back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = VALID;
      VALID:   if (out_ready_i && !grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      last_grant_q <= ID_W'(NUM_SRC - 1);
      out_id_q     <= '0;
      out_cnt_q    <= '0;
      out_info_q   <= '0;
      drop_q       <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (grant) begin
        out_id_q     <= grant_id;
        out_cnt_q    <= grant_cnt;
        out_info_q   <= info_i;
        last_grant_q <= grant_id;
      end
      drop_q     <= |drop_vec;
      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign out_valid_o = (state_q == VALID);
  assign out_id_o    = out_id_q;
  assign out_cnt_o   = out_cnt_q;
  assign out_info_o  = out_info_q;
  assign drop_o      = drop_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_evu_evt_sched.sv
// tb_evu_evt_sched: scoreboard bench for evu_evt_sched with directed scenarios
// followed by randomized traffic, resets and backpressure.
// A reference model predicts records and drop counters; a monitor checks them.
module tb_evu_evt_sched;

  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int IW   = 18;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  mask;
  logic [N-1:0]  evt;
  logic [IW-1:0] info;
  logic          rdy;
  logic          out_valid;
  logic [1:0]    out_id;
  logic [CW-1:0] out_cnt;
  logic [IW-1:0] out_info;
  logic          drop;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  evu_evt_sched #(.NUM_SRC(N), .CNT_W(CW), .INFO_W(IW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .src_mask_i (mask),
    .evt_i      (evt),
    .info_i     (info),
    .out_valid_o(out_valid),
    .out_ready_i(rdy),
    .out_id_o   (out_id),
    .out_cnt_o  (out_cnt),
    .out_info_o (out_info),
    .drop_o     (drop),
    .drop_cnt_o (drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int id;
    int cnt;
    int info;
  } rec_t;

  rec_t exp_q[$];
  int   m_pend[N];
  int   m_last  = N - 1;
  bit   m_valid = 1'b0;
  bit   m_drop  = 1'b0;
  int   m_dcnt  = 0;
  bit   mon_on  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model, advanced once per rising edge using the inputs the DUT
  // sees at that edge. Plain counters: a grant empties the chosen source,
  // then the cycle's accepted events are added, anything beyond MAXC is lost.
  task automatic model_step();
    bit gr;
    int gk;
    int nd;
    bit lok;
    if (!rst_n) begin
      foreach (m_pend[k]) m_pend[k] = 0;
      m_last  = N - 1;
      m_valid = 1'b0;
      m_drop  = 1'b0;
      m_dcnt  = 0;
      exp_q.delete();
    end else begin
      gr  = 1'b0;
      gk  = 0;
      nd  = 0;
      lok = !m_valid || rdy;
      if (lok && en) begin
        for (int o = 1; o <= N; o++) begin
          if (!gr && m_pend[(m_last + o) % N] > 0) begin
            gr = 1'b1;
            gk = (m_last + o) % N;
          end
        end
      end
      if (gr) begin
        exp_q.push_back('{gk, m_pend[gk], int'(info)});
        m_pend[gk] = 0;
        m_last     = gk;
      end
      for (int k = 0; k < N; k++) begin
        if (evt[k] && mask[k] && en) begin
          if (m_pend[k] == MAXC) nd++;
          else m_pend[k]++;
        end
      end
      m_valid = gr || (m_valid && !rdy);
      m_drop  = (nd > 0);
      m_dcnt  = (m_dcnt + nd > 65535) ? 65535 : m_dcnt + nd;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compares whatever the DUT presents against the queue head and
  // retires the head on a completed handshake.
  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      chk("sb_valid", int'(out_valid), int'(m_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got record id %0d cnt %0d, expected no record",
                   out_id, out_cnt);
        end else begin
          chk("sb_id",   int'(out_id),   exp_q[0].id);
          chk("sb_cnt",  int'(out_cnt),  exp_q[0].cnt);
          chk("sb_info", int'(out_info), exp_q[0].info);
          if (rdy) void'(exp_q.pop_front());
        end
      end
      chk("sb_drop_o",   int'(drop),     int'(m_drop));
      chk("sb_drop_cnt", int'(drop_cnt), m_dcnt);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    evt   = '0;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    int'(out_valid), 0);
    chk({tag, "_id"},       int'(out_id),    0);
    chk({tag, "_cnt"},      int'(out_cnt),   0);
    chk({tag, "_info"},     int'(out_info),  0);
    chk({tag, "_drop"},     int'(drop),      0);
    chk({tag, "_drop_cnt"}, int'(drop_cnt),  0);
  endtask

  int r32_id[4]  = '{1, 2, 3, 0};
  int r32_cnt[4] = '{3, 3, 3, 2};

  initial begin
    int highs;
    int rdy_pct;
    bit dense;

    rst_n = 1'b0; en = 1'b0; mask = '0; evt = '0; info = '0; rdy = 1'b0;
    step(2);
    mon_on = 1'b1;
    chk_all_zero("reset");

    // Single event, ready consumer.
    rst_n = 1'b1; en = 1'b1; mask = '1; rdy = 1'b1; info = 18'h2A5A5;
    evt = 4'b0001;
    step(1);
    evt = '0;
    step(1);
    chk("single_valid", int'(out_valid), 1);
    chk("single_id",    int'(out_id),    0);
    chk("single_cnt",   int'(out_cnt),   1);
    chk("single_info",  int'(out_info),  int'(18'h2A5A5));
    step(1);
    chk("single_idle",  int'(out_valid), 0);

    // All sources firing under backpressure, then a burst of records.
    do_reset();
    rdy = 1'b0; evt = '1;
    step(3);
    evt = '0;
    chk("rr_first_id",  int'(out_id),  0);
    chk("rr_first_cnt", int'(out_cnt), 1);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("rr_burst_valid", int'(out_valid), 1);
      chk("rr_burst_id",    int'(out_id),    r32_id[i]);
      chk("rr_burst_cnt",   int'(out_cnt),   r32_cnt[i]);
    end
    step(1);
    chk("rr_idle", int'(out_valid), 0);

    // Saturation with a held record: 20 events on source 2, 5 lost.
    do_reset();
    rdy = 1'b0; evt = 4'b0001;
    step(1);
    evt = '0;
    step(1);
    evt = 4'b0100;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (drop) highs++;
    end
    evt = '0;
    step(1);
    chk("sat_drop_low",   int'(drop),      0);
    chk("sat_drop_highs", highs,           5);
    chk("sat_drop_cnt",   int'(drop_cnt),  5);
    chk("sat_held_valid", int'(out_valid), 1);
    chk("sat_held_id",    int'(out_id),    0);
    chk("sat_held_cnt",   int'(out_cnt),   1);

    // Grant of source 1 in the same cycle as a new event on source 1.
    do_reset();
    rdy = 1'b0; evt = 4'b0001;
    step(1);
    evt = 4'b0010;
    step(2);
    evt = '0;
    chk("same_held_id", int'(out_id), 0);
    rdy = 1'b1; evt = 4'b0010;
    step(1);
    evt = '0;
    chk("same_old_id",  int'(out_id),  1);
    chk("same_old_cnt", int'(out_cnt), 2);
    step(1);
    chk("same_next_id",  int'(out_id),  1);
    chk("same_next_cnt", int'(out_cnt), 1);
    step(1);
    chk("same_idle", int'(out_valid), 0);

    // Disable while a record is held and source 3 has 2 pending.
    do_reset();
    rdy = 1'b0; evt = 4'b1000;
    step(3);
    evt = '0;
    chk("dis_held_id",  int'(out_id),  3);
    chk("dis_held_cnt", int'(out_cnt), 1);
    en = 1'b0; rdy = 1'b1;
    step(1);
    chk("dis_accepted", int'(out_valid), 0);
    step(3);
    chk("dis_no_grant", int'(out_valid), 0);
    en = 1'b1;
    step(1);
    chk("dis_resume_valid", int'(out_valid), 1);
    chk("dis_resume_id",    int'(out_id),    3);
    chk("dis_resume_cnt",   int'(out_cnt),   2);

    // Reset while a record is held and 7 events have been lost.
    do_reset();
    rdy = 1'b0; evt = 4'b0001;
    step(1);
    evt = '0;
    step(1);
    evt = 4'b0100;
    step(22);
    evt = '0;
    step(1);
    chk("rst_pre_drop_cnt", int'(drop_cnt),  7);
    chk("rst_pre_valid",    int'(out_valid), 1);
    rst_n = 1'b0;
    step(1);
    chk_all_zero("midrst");
    rst_n = 1'b1;
    step(1);
    chk("midrst_no_rec", int'(out_valid), 0);

    // Randomized traffic: alternating backpressure phases, mask changes,
    // enable gaps and rare resets; all checking is done by the scoreboard.
    do_reset();
    mask = '1;
    for (int c = 0; c < 4000; c++) begin
      dense   = ((c / 500) % 2) == 1;
      rdy_pct = dense ? 20 : 85;
      en      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 31) == 0) mask = N'($urandom);
      evt     = dense ? N'($urandom) : N'($urandom & $urandom & $urandom);
      info    = IW'($urandom);
      rdy     = ($urandom_range(0, 99) < rdy_pct);
      rst_n   = ($urandom_range(0, 999) != 0);
      step(1);
    end

    // Drain everything still pending.
    rst_n = 1'b1; en = 1'b1; evt = '0; rdy = 1'b1;
    step(40);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_idle",        int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
